// File: rtl/sync_arith_pkg.sv
// sync_arith_pkg: shared op encodings and status bit positions for the arithmetic unit.
package sync_arith_pkg;
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ABS = 2'd2,
        OP_CMP = 2'd3
    } op_e;

    localparam int ST_NEG  = 0;
    localparam int ST_ZERO = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_ERR  = 3;
    localparam int ST_W    = 4;
endpackage

// File: rtl/sync_arith_addsub.sv
// sync_arith_addsub: combinational BITS-wide adder/subtractor with carry-out and signed overflow.
module sync_arith_addsub #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic            sub_i,
    output logic [BITS-1:0] sum_o,
    output logic            carry_o,
    output logic            ovf_o
);
    logic [BITS-1:0] b_eff;

    assign b_eff            = sub_i ? ~b_i : b_i;
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{BITS{1'b0}}, sub_i};
    // Overflow when both addends agree in sign but the sum does not.
    assign ovf_o            = (a_i[BITS-1] == b_eff[BITS-1]) && (sum_o[BITS-1] != a_i[BITS-1]);
endmodule

// File: rtl/sync_arith_unit_12_core.sv
// sync_arith_unit_12_core: registered signed ADD/SUB/ABS/CMP with {ERR,OVF,ZERO,NEG} status.
// Optional build macro SYNC_ARITH_SAT_EN saturates ADD/SUB/ABS results on overflow.
module sync_arith_unit_12_core
    import sync_arith_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [BITS-1:0] i_arg_A,
    input  logic [BITS-1:0] i_arg_B,
    input  logic [1:0]      i_op,
    output logic [BITS-1:0] o_result,
    output logic [ST_W-1:0] o_status
);
    op_e             op;
    logic [BITS-1:0] as_a, as_b, as_sum, raw, res;
    logic            as_sub, as_carry, as_ovf, neg_a, err, ovf, lt;
    logic [BITS-1:0] result_d, result_q;
    logic [ST_W-1:0] status_d, status_q;

    assign op     = op_e'(i_op);
    assign neg_a  = i_arg_A[BITS-1];
    // ABS shares the subtractor as 0 - A; CMP shares it as A - B.
    assign as_a   = (op == OP_ABS) ? '0 : i_arg_A;
    assign as_b   = (op == OP_ABS) ? i_arg_A : i_arg_B;
    assign as_sub = (op != OP_ADD);

    sync_arith_addsub #(.BITS(BITS)) u_addsub (
        .a_i     (as_a),
        .b_i     (as_b),
        .sub_i   (as_sub),
        .sum_o   (as_sum),
        .carry_o (as_carry),
        .ovf_o   (as_ovf)
    );

`ifdef SYNC_ARITH_SAT_EN
    localparam logic [BITS-1:0] SMAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
`endif

    always_comb begin
        // Mixed signs decide directly; equal signs reduce to unsigned borrow (no carry out).
        lt  = (i_arg_A[BITS-1] ^ i_arg_B[BITS-1]) ? neg_a : ~as_carry;
        err = (op == OP_ABS) && (|i_arg_B);
        ovf = (op == OP_ABS) ? (neg_a & as_ovf) : (op == OP_CMP) ? 1'b0 : as_ovf;
        raw = (op == OP_CMP) ? {{(BITS-1){1'b0}}, lt} :
              (op == OP_ABS && !neg_a) ? i_arg_A : as_sum;
`ifdef SYNC_ARITH_SAT_EN
        // A wrapped negative result means the true value overflowed upward.
        res = ovf ? (raw[BITS-1] ? SMAX : SMIN) : raw;
`else
        res = raw;
`endif
        result_d           = err ? '0 : res;
        status_d           = '0;
        status_d[ST_ERR]   = err;
        status_d[ST_OVF]   = ~err & ovf;
        status_d[ST_ZERO]  = ~err & (res == '0);
        status_d[ST_NEG]   = ~err & res[BITS-1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            result_q <= '0;
            status_q <= '0;
        end else begin
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign o_result = result_q;
    assign o_status = status_q;
endmodule

// File: tb/tb_sync_arith_unit_12_core.sv
// tb_sync_arith_unit_12_core: scoreboard bench with directed vectors, random traffic and reset checks.
module tb_sync_arith_unit_12_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  op = '0;
    logic [31:0] res;
    logic [3:0]  st;
    logic [35:0] sb_q[$];
    int          n_cmp = 0, n_bad = 0, n_seen = 0;

    sync_arith_unit_12_core #(.BITS(32)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_arg_A  (a),
        .i_arg_B  (b),
        .i_op     (op),
        .o_result (res),
        .o_status (st)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, s;
        logic [31:0] r;
        logic ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0:    s = sx + sy;
            2'd1:    s = sx - sy;
            2'd2:    s = (sx < 0) ? -sx : sx;
            default: s = (sx < sy) ? 1 : 0;
        endcase
        ov = (o != 2'd3) && (s > 64'sd2147483647 || s < -64'sd2147483648);
        r  = s[31:0];
`ifdef SYNC_ARITH_SAT_EN
        if (ov) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        if (o == 2'd2 && y != 0) return {4'b1000, 32'h0};
        return {1'b0, ov, r == 0, r[31], r};
    endfunction

    task automatic check(input string name, input logic [31:0] er, input logic [3:0] es);
        n_cmp++;
        if (res !== er || st !== es) begin
            n_bad++;
            $display("FAIL %s: got result=%h status=%b, expected result=%h status=%b", name, res, st, er, es);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [35:0] e);
        op = o;
        a  = x;
        b  = y;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are valid 1 time unit after each capturing edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            logic [35:0] e;
            e = sb_q.pop_front();
            n_seen++;
            check($sformatf("vec%0d", n_seen), e[31:0], e[35:32]);
        end
    end

    initial begin
        #1;
        check("reset_at_once", 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            check("reset_hold", 32'h0, 4'h0);
        end
        #2;
        rst = 1'b0;
`ifdef SYNC_ARITH_SAT_EN
        issue(2'd0, 32'h7FFF_FFFF, 32'h1,         {4'b0100, 32'h7FFF_FFFF});
        issue(2'd2, 32'h8000_0000, 32'h0,         {4'b0100, 32'h7FFF_FFFF});
        issue(2'd1, 32'h8000_0000, 32'h1,         {4'b0101, 32'h8000_0000});
        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, {4'b0101, 32'h8000_0000});
`else
        issue(2'd0, 32'h7FFF_FFFF, 32'h1,         {4'b0101, 32'h8000_0000});
        issue(2'd2, 32'h8000_0000, 32'h0,         {4'b0101, 32'h8000_0000});
        issue(2'd1, 32'h8000_0000, 32'h1,         {4'b0100, 32'h7FFF_FFFF});
        issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, {4'b0100, 32'h7FFF_FFFF});
`endif
        issue(2'd1, 32'd5,         32'd5,         {4'b0010, 32'h0});
        issue(2'd1, 32'd3,         32'd7,         {4'b0001, 32'hFFFF_FFFC});
        issue(2'd2, 32'hFFFF_FFF6, 32'h0,         {4'b0000, 32'd10});
        issue(2'd2, 32'd10,        32'd3,         {4'b1000, 32'h0});
        issue(2'd2, 32'd0,         32'd1,         {4'b1000, 32'h0});
        issue(2'd3, 32'hFFFF_FFFF, 32'h0,         {4'b0000, 32'd1});
        issue(2'd3, 32'h0,         32'hFFFF_FFFF, {4'b0010, 32'd0});
        issue(2'd3, 32'h8000_0000, 32'h1,         {4'b0000, 32'd1});
        issue(2'd3, 32'h7FFF_FFFF, 32'h8000_0000, {4'b0010, 32'd0});
        issue(2'd0, 32'd100,       32'hFFFF_FF9C, {4'b0010, 32'd0});
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = (i % 8 == 0) ? 32'h8000_0000 : $urandom;
            y = (o == 2'd2) ? 32'h0 : $urandom;
            issue(o, x, y, model(o, x, y));
        end
        // Mid-stream reset: load a nonzero result, then clear it asynchronously.
        issue(2'd0, 32'd1, 32'd2, {4'b0000, 32'd3});
        rst = 1'b1;
        #1;
        check("reset_async", 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", 32'h0, 4'h0);
        #2;
        rst = 1'b0;
        issue(2'd1, 32'd1, 32'd2, {4'b0001, 32'hFFFF_FFFF});
        issue(2'd2, 32'hFFFF_FFFF, 32'h0, {4'b0000, 32'd1});
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
